// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO sizing constants for fifo_ctrl and dualPortRAM
package fifo_pkg;
  localparam int DEFAULT_ADDR_WIDTH = 12;
  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEPTH              = 1 << DEFAULT_ADDR_WIDTH;
endpackage

// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - pointer/flag controller turning a dual-port RAM into a synchronous FIFO
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH      = DEFAULT_ADDR_WIDTH,
  parameter int ALMOST_FULL_LVL = (1 << ADDR_WIDTH) - 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [ADDR_WIDTH-1:0] read_addr_1,
  output logic [ADDR_WIDTH-1:0] read_addr_2,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] AF_LVL = (ADDR_WIDTH + 1)'(ALMOST_FULL_LVL);

  // extra MSB is the wrap bit: equal low bits with differing MSBs means full
  logic [ADDR_WIDTH:0] wptr, rptr;
  logic [ADDR_WIDTH:0] wptr_nxt, rptr_nxt, level_nxt;
  logic                push_ok, pop_ok;

  // a push into a full FIFO is accepted when a pop frees the head slot in the same edge
  assign push_ok = wr & (~full | rd);
  assign pop_ok  = rd & ~empty;

  assign we          = push_ok & ~reset;
  assign write_addr  = wptr[ADDR_WIDTH-1:0];
  assign read_addr_1 = rptr[ADDR_WIDTH-1:0];
  assign read_addr_2 = read_addr_1 + ADDR_WIDTH'(1);

  assign wptr_nxt  = wptr + (ADDR_WIDTH + 1)'(push_ok);
  assign rptr_nxt  = rptr + (ADDR_WIDTH + 1)'(pop_ok);
  assign level_nxt = wptr_nxt - rptr_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr        <= '0;
      rptr        <= '0;
      level       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      wptr        <= wptr_nxt;
      rptr        <= rptr_nxt;
      level       <= level_nxt;
      empty       <= (wptr_nxt == rptr_nxt);
      full        <= (wptr_nxt[ADDR_WIDTH-1:0] == rptr_nxt[ADDR_WIDTH-1:0]) &&
                     (wptr_nxt[ADDR_WIDTH] != rptr_nxt[ADDR_WIDTH]);
      almost_full <= (level_nxt >= AF_LVL);
      overflow    <= wr & ~push_ok;
      // a simultaneous push on empty turns the pop into a no-op, not an error
      underflow   <= rd & empty & ~wr;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb/tb_fifo_ctrl.sv - directed self-checking bench for fifo_ctrl at depth 4
module tb_fifo_ctrl;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset, wr, rd;
  logic          we, full, empty, almost_full, overflow, underflow;
  logic [AW-1:0] write_addr, read_addr_1, read_addr_2;
  logic [AW:0]   level;
  logic [7:0]    write_data;
  logic [7:0]    mem [0:3];
  logic [7:0]    read_data_1;
  int            total = 0;
  int            passed = 0;
  int            ra;

  fifo_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .wr(wr), .rd(rd), .we(we),
    .write_addr(write_addr), .read_addr_1(read_addr_1), .read_addr_2(read_addr_2),
    .full(full), .empty(empty), .almost_full(almost_full), .level(level),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // behavioural stand-in for dualPortRAM: write at the edge, combinational read
  always @(posedge clk) if (we) mem[write_addr] <= write_data;
  assign read_data_1 = mem[read_addr_1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) mem[i] = 8'h00;
    reset = 1'b1; wr = 1'b1; rd = 1'b0; write_data = 8'h55;
    #1;
    chk("rst_we_comb", we, 0);
    cyc();
    chk("rst_we", we, 0);
    chk("rst_empty", empty, 1);
    chk("rst_level", level, 0);
    cyc();
    chk("rst_full", full, 0);
    chk("rst_af", almost_full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);

    // fill: A1..A4
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr = 1'b1; write_data = 8'hA1 + 8'(i);
      #1;
      chk("push_we", we, 1);
      chk("push_waddr", write_addr, i);
      cyc();
      chk("push_level", level, i + 1);
      chk("push_af", almost_full, (i + 1 >= 2) ? 1 : 0);
      chk("push_full", full, (i == 3) ? 1 : 0);
      chk("push_empty", empty, 0);
    end
    write_data = 8'hEE;
    #1;
    chk("ovf_we", we, 0);
    cyc();
    chk("ovf_pulse", overflow, 1);
    chk("ovf_level", level, 4);
    wr = 1'b0;
    cyc();
    chk("ovf_clear", overflow, 0);

    // drain
    for (int i = 0; i < 4; i++) begin
      rd = 1'b1;
      #1;
      chk("pop_raddr1", read_addr_1, i);
      chk("pop_raddr2", read_addr_2, (i + 1) % 4);
      chk("pop_data", read_data_1, 8'hA1 + i);
      cyc();
      chk("pop_level", level, 3 - i);
    end
    chk("drain_empty", empty, 1);
    chk("drain_full", full, 0);
    cyc();
    chk("unf_pulse", underflow, 1);
    chk("unf_rptr", read_addr_1, 0);
    rd = 1'b0;
    cyc();
    chk("unf_clear", underflow, 0);
    chk("unf_rptr_hold", read_addr_1, 0);

    // wr&rd on empty acts as push only
    wr = 1'b1; rd = 1'b1; write_data = 8'hB0;
    cyc();
    chk("wrrd_empty_level", level, 1);
    chk("wrrd_empty_unf", underflow, 0);
    rd = 1'b0;
    for (int i = 1; i < 4; i++) begin
      write_data = 8'hB0 + 8'(i);
      cyc();
    end
    chk("refill_full", full, 1);

    // wr&rd on full: write lands in the slot being popped
    rd = 1'b1; write_data = 8'hC0;
    #1;
    chk("wrrd_full_we", we, 1);
    chk("wrrd_full_waddr", write_addr, 0);
    chk("wrrd_full_raddr", read_addr_1, 0);
    chk("wrrd_full_data", read_data_1, 8'hB0);
    cyc();
    chk("wrrd_full_level", level, 4);
    chk("wrrd_full_flag", full, 1);
    chk("wrrd_full_ovf", overflow, 0);
    wr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("wrrd_drain_data", read_data_1, (i < 3) ? (8'hB1 + i) : 8'hC0);
      cyc();
    end
    chk("wrrd_drain_empty", empty, 1);

    // wrap at level 1
    rd = 1'b0; wr = 1'b1; write_data = 8'hD0;
    cyc();
    rd = 1'b1;
    ra = 1;
    for (int k = 0; k < 10; k++) begin
      write_data = 8'hD1 + 8'(k);
      #1;
      chk("wrap_raddr1", read_addr_1, ra);
      chk("wrap_raddr2", read_addr_2, (ra + 1) % 4);
      chk("wrap_data", read_data_1, 8'hD0 + k);
      cyc();
      chk("wrap_level", level, 1);
      ra = (ra + 1) % 4;
    end
    wr = 1'b0;
    #1;
    chk("wrap_last_data", read_data_1, 8'hDA);
    cyc();
    rd = 1'b0;
    chk("wrap_empty", empty, 1);

    // reset at level 3 discards contents
    wr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      write_data = 8'hE0 + 8'(i);
      cyc();
    end
    chk("pre_rst_level", level, 3);
    reset = 1'b1; wr = 1'b0;
    cyc();
    chk("mid_rst_level", level, 0);
    chk("mid_rst_empty", empty, 1);
    reset = 1'b0; wr = 1'b1; write_data = 8'hF0;
    #1;
    chk("post_rst_waddr", write_addr, 0);
    cyc();
    wr = 1'b0; rd = 1'b1;
    #1;
    chk("post_rst_raddr", read_addr_1, 0);
    chk("post_rst_data", read_data_1, 8'hF0);
    cyc();
    rd = 1'b0;
    chk("post_rst_empty", empty, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
